// File: rtl/bshifter_seq_4bit.sv
`default_nettype none
// bshifter_seq_4bit: sweeps all four shift amounts of an external 4-bit barrel shifter over a latched operand.
// Optional macro BSEQ_CHECK_EN adds a sticky err flag checking each capture against a rotate-right reference.
module bshifter_seq_4bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  din,
  output logic        s1,
  output logic        s0,
  output logic        w3,
  output logic        w2,
  output logic        w1,
  output logic        w0,
  input  logic        y3,
  input  logic        y2,
  input  logic        y1,
  input  logic        y0,
  output logic        busy,
  output logic        done,
  output logic [15:0] result
`ifdef BSEQ_CHECK_EN
  ,
  output logic        err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [1:0]  sel;
  logic [3:0]  operand;
  logic [11:0] shadow;
  logic [3:0]  y;

  assign y            = {y3, y2, y1, y0};
  assign {s1, s0}     = sel;
  assign {w3, w2, w1, w0} = operand;

  // sel is registered one step ahead so it equals cnt throughout each RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      sel     <= 2'd0;
      operand <= 4'd0;
      shadow  <= 12'd0;
      result  <= 16'h0000;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            operand <= din;
            cnt     <= 2'd0;
            sel     <= 2'd0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          case (cnt)
            2'd0:    shadow[3:0]  <= y;
            2'd1:    shadow[7:4]  <= y;
            2'd2:    shadow[11:8] <= y;
            default: ;
          endcase
          if (cnt == 2'd3) begin
            // Field 3 is captured on the same edge, so it bypasses the shadow.
            result <= {y, shadow};
            sel    <= 2'd0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt + 2'd1;
            sel <= cnt + 2'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BSEQ_CHECK_EN
  function automatic logic [3:0] rotr(input logic [3:0] v, input logic [1:0] n);
    case (n)
      2'd0:    rotr = v;
      2'd1:    rotr = {v[0], v[3:1]};
      2'd2:    rotr = {v[1:0], v[3:2]};
      default: rotr = {v[2:0], v[3]};
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (state == RUN && y != rotr(operand, cnt)) begin
      err <= 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bshifter_seq_4bit.sv
`default_nettype none
// tb_bshifter_seq_4bit: directed self-checking bench with a rotate-right barrel shifter model and fault injection.
module tb_bshifter_seq_4bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  din;
  logic        s1, s0, w3, w2, w1, w0;
  logic        y3, y2, y1, y0;
  logic        busy, done;
  logic [15:0] result;
`ifdef BSEQ_CHECK_EN
  logic        err;
`endif

  logic        fault;
  logic [3:0]  wv;
  logic [3:0]  yv;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bshifter_seq_4bit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .din    (din),
    .s1     (s1),
    .s0     (s0),
    .w3     (w3),
    .w2     (w2),
    .w1     (w1),
    .w0     (w0),
    .y3     (y3),
    .y2     (y2),
    .y1     (y1),
    .y0     (y0),
    .busy   (busy),
    .done   (done),
    .result (result)
`ifdef BSEQ_CHECK_EN
    ,
    .err    (err)
`endif
  );

  // Downstream barrel shifter: rotate right by {s1,s0}, optionally broken at amount 2.
  always_comb begin
    wv = {w3, w2, w1, w0};
    yv = wv;
    case ({s1, s0})
      2'd0:    yv = wv;
      2'd1:    yv = {wv[0], wv[3:1]};
      2'd2:    yv = {wv[1:0], wv[3:2]};
      default: yv = {wv[2:0], wv[3]};
    endcase
    if (fault && {s1, s0} == 2'd2) yv = 4'b0000;
  end
  assign {y3, y2, y1, y0} = yv;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Waits for done with a bound; reports the latency in cycles from the start-driving negedge.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1) start = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
    end
    check("done_timeout", {15'd0, (lat > 0)}, 16'd1);
  endtask

  initial begin
    int lat;
    int ndone;
    int first_done;
    int second_done;
    logic seen;

    rst   = 1'b1;
    start = 1'b0;
    din   = 4'd0;
    fault = 1'b0;
    tick();
    tick();
    check("rst_result", result, 16'h0000);
    check("rst_ctrl", {12'd0, busy, done, s1, s0}, 16'd0);
    check("rst_w", {12'd0, w3, w2, w1, w0}, 16'd0);
`ifdef BSEQ_CHECK_EN
    check("rst_err", {15'd0, err}, 16'd0);
`endif
    rst = 1'b0;
    tick();
    check("idle_busy", {15'd0, busy}, 16'd0);

    // Normal sweep with select trace, din change and an ignored start pulse mid-RUN.
    din   = 4'b1101;
    start = 1'b1;
    tick();
    start = 1'b0;
    din   = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("run%0d_sel", i), {14'd0, s1, s0}, 16'(i));
      check($sformatf("run%0d_w", i), {12'd0, w3, w2, w1, w0}, 16'hD);
      check($sformatf("run%0d_busy_done", i), {14'd0, busy, done}, 16'b10);
      if (i == 1) begin
        start = 1'b1;
        din   = 4'b0001;
      end
      if (i == 2) start = 1'b0;
      tick();
    end
    check("sweep1_done", {15'd0, done}, 16'd1);
    check("sweep1_result", result, 16'hB7ED);
    check("done_sel", {14'd0, s1, s0}, 16'd0);
    check("done_busy", {15'd0, busy}, 16'd1);
`ifdef BSEQ_CHECK_EN
    check("sweep1_err", {15'd0, err}, 16'd0);
`endif
    tick();
    check("after_done", {14'd0, busy, done}, 16'd0);
    check("idle_w_hold", {12'd0, w3, w2, w1, w0}, 16'hD);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (busy || done) seen = 1'b1;
    end
    check("no_second_sweep", {15'd0, seen}, 16'd0);
    check("result_hold", result, 16'hB7ED);

    // Back-to-back: start held high for 12 cycles.
    din         = 4'b1000;
    start       = 1'b1;
    ndone       = 0;
    first_done  = 0;
    second_done = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 12) start = 1'b0;
      if (done) begin
        ndone++;
        if (ndone == 1) first_done = c;
        if (ndone == 2) second_done = c;
        check($sformatf("b2b_result%0d", ndone), result, 16'h1248);
      end
    end
    check("b2b_count", 16'(ndone), 16'd2);
    check("b2b_first", 16'(first_done), 16'd5);
    check("b2b_gap", 16'(second_done - first_done), 16'd6);

    // Reset at the second RUN cycle aborts the sweep.
    din   = 4'b0110;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_result", result, 16'h0000);
    check("abort_ctrl", {12'd0, busy, done, s1, s0}, 16'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    check("abort_no_done", {15'd0, seen}, 16'd0);
    din   = 4'b0110;
    start = 1'b1;
    wait_done(lat);
    check("fresh_latency", 16'(lat), 16'd5);
    check("fresh_result", result, 16'hC936);
    tick();

    // Broken shifter at amount 2.
    fault = 1'b1;
    din   = 4'b1101;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
`ifdef BSEQ_CHECK_EN
    check("fault_err_before", {15'd0, err}, 16'd0);
`endif
    tick();
`ifdef BSEQ_CHECK_EN
    check("fault_err_set", {15'd0, err}, 16'd1);
`endif
    tick();
    check("fault_done", {15'd0, done}, 16'd1);
    check("fault_result", result, 16'hB0ED);
    tick();
    fault = 1'b0;
`ifdef BSEQ_CHECK_EN
    check("fault_err_after_done", {15'd0, err}, 16'd1);
`endif
    din   = 4'b1101;
    start = 1'b1;
    wait_done(lat);
    check("clean_result", result, 16'hB7ED);
`ifdef BSEQ_CHECK_EN
    check("err_sticky", {15'd0, err}, 16'd1);
`endif
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
`ifdef BSEQ_CHECK_EN
    check("err_cleared", {15'd0, err}, 16'd0);
`endif
    check("final_result", result, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
